// File: rtl/ysyx_22041412_axi_pkg.sv
// Shared types for the single-port AXI scheduler:
// state encodings, burst-size constant, grant one-hot.
package ysyx_22041412_axi_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE = 2'd0,
    G_IF       = 2'd1,
    G_MR       = 2'd2,
    G_MW       = 2'd3
  } sched_state_e;

  localparam logic [2:0] BUST_8 = 3'b011;

  typedef struct packed {
    logic mw;
    logic mr;
    logic ifr;
  } grant_t;

  localparam grant_t GNT_NONE = '0;

endpackage

// File: rtl/ysyx_22041412_sched_prio.sv
// Combinational picker: fixed priority MEM-W > MEM-R > IF,
// IF forced when starve_i reaches STARVE_LIMIT. Out: one-hot grant.
module ysyx_22041412_sched_prio
  import ysyx_22041412_axi_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       if_valid_i,
  input  logic       mr_valid_i,
  input  logic       mw_valid_i,
  input  logic [2:0] starve_i,
  output grant_t     grant_o
);

  localparam logic [2:0] LIM = 3'(STARVE_LIMIT);

  always_comb begin
    grant_o = GNT_NONE;
    if (if_valid_i && starve_i == LIM) grant_o.ifr = 1'b1;
    else if (mw_valid_i)               grant_o.mw  = 1'b1;
    else if (mr_valid_i)               grant_o.mr  = 1'b1;
    else if (if_valid_i)               grant_o.ifr = 1'b1;
  end

endmodule

// File: rtl/ysyx_22041412_axi_sched.sv
// One-transaction-at-a-time scheduler of IF read, MEM read, MEM write
// onto a shared bridge port (bus_*); owner gets the zero-latency return path.
module ysyx_22041412_axi_sched
  import ysyx_22041412_axi_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_ar_valid,
  input  logic [AXI_ADDR_WIDTH-1:0] if_ar_addr,
  input  logic [7:0]                if_ar_len,
  output logic                      if_ar_ready,
  output logic [AXI_DATA_WIDTH-1:0] if_ar_data,
  output logic                      if_last_i,
  input  logic                      mem_r_valid,
  input  logic [AXI_ADDR_WIDTH-1:0] mem_r_addr,
  input  logic [7:0]                mem_r_len,
  output logic                      mem_r_ready,
  output logic [AXI_DATA_WIDTH-1:0] mem_r_data,
  output logic                      mem_r_last_i,
  input  logic                      mem_w_valid,
  input  logic [AXI_ADDR_WIDTH-1:0] mem_w_addr,
  input  logic [7:0]                mem_w_len,
  input  logic [2:0]                mem_w_size,
  input  logic [AXI_DATA_WIDTH-1:0] mem_w_data,
  output logic                      mem_w_ready,
  output logic                      mem_w_last_i,
  output logic                      bus_valid,
  output logic                      bus_wen,
  output logic [AXI_ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]                bus_len,
  output logic [2:0]                bus_size,
  output logic [AXI_DATA_WIDTH-1:0] bus_wdata,
  input  logic                      bus_ready,
  input  logic [AXI_DATA_WIDTH-1:0] bus_rdata,
  input  logic                      bus_last
);

  localparam logic [2:0] LIM = 3'(STARVE_LIMIT);

  sched_state_e state_q, state_d;
  grant_t       grant_q, grant_d, pick;
  logic [7:0]   beat_q, beat_d;
  logic [2:0]   starve_q, starve_d;
  logic         err_q, err_d;

  logic                      own_v;
  logic [AXI_ADDR_WIDTH-1:0] own_addr;
  logic [7:0]                own_len;

  ysyx_22041412_sched_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .if_valid_i(if_ar_valid),
    .mr_valid_i(mem_r_valid),
    .mw_valid_i(mem_w_valid),
    .starve_i  (starve_q),
    .grant_o   (pick)
  );

  always_comb begin
    own_v    = 1'b0;
    own_addr = '0;
    own_len  = '0;
    unique case (1'b1)
      grant_q.ifr: begin
        own_v    = if_ar_valid;
        own_addr = if_ar_addr;
        own_len  = if_ar_len;
      end
      grant_q.mr: begin
        own_v    = mem_r_valid;
        own_addr = mem_r_addr;
        own_len  = mem_r_len;
      end
      grant_q.mw: begin
        own_v    = mem_w_valid;
        own_addr = mem_w_addr;
        own_len  = mem_w_len;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SCHED_IDLE;
      grant_q  <= GNT_NONE;
      beat_q   <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      beat_q   <= beat_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    beat_d   = beat_q;
    starve_d = starve_q;
    err_d    = err_q;
    unique case (state_q)
      SCHED_IDLE: begin
        grant_d = pick;
        beat_d  = '0;
        unique case (1'b1)
          pick.ifr: state_d = G_IF;
          pick.mr:  state_d = G_MR;
          pick.mw:  state_d = G_MW;
          default:  state_d = SCHED_IDLE;
        endcase
        if (!if_ar_valid || pick.ifr)
          starve_d = '0;
        else if ((pick.mr || pick.mw) && starve_q != LIM)
          starve_d = starve_q + 3'd1;
      end
      default: begin
        if (bus_ready) begin
          beat_d = beat_q + 8'd1;
          if (bus_last) begin
            state_d = SCHED_IDLE;
            grant_d = GNT_NONE;
            if (beat_q != own_len) err_d = 1'b1;
          end
        end else if (beat_q == 8'd0 && !own_v) begin
          // requester withdrew before any beat: cancel
          state_d = SCHED_IDLE;
          grant_d = GNT_NONE;
        end
      end
    endcase
  end

  always_comb begin
    bus_valid    = 1'b0;
    bus_wen      = 1'b0;
    bus_addr     = '0;
    bus_len      = '0;
    bus_size     = '0;
    bus_wdata    = '0;
    if_ar_ready  = 1'b0;
    if_ar_data   = '0;
    if_last_i    = 1'b0;
    mem_r_ready  = 1'b0;
    mem_r_data   = '0;
    mem_r_last_i = 1'b0;
    mem_w_ready  = 1'b0;
    mem_w_last_i = 1'b0;
    // rst gates outputs in the very cycle it is asserted
    if (!rst) begin
      unique case (state_q)
        G_IF: begin
          bus_valid   = own_v;
          bus_addr    = own_addr;
          bus_len     = own_len;
          bus_size    = BUST_8;
          if_ar_ready = bus_ready;
          if_ar_data  = bus_rdata;
          if_last_i   = bus_last;
        end
        G_MR: begin
          bus_valid    = own_v;
          bus_addr     = own_addr;
          bus_len      = own_len;
          bus_size     = BUST_8;
          mem_r_ready  = bus_ready;
          mem_r_data   = bus_rdata;
          mem_r_last_i = bus_last;
        end
        G_MW: begin
          bus_valid    = own_v;
          bus_wen      = 1'b1;
          bus_addr     = own_addr;
          bus_len      = own_len;
          bus_size     = mem_w_size;
          bus_wdata    = mem_w_data;
          mem_w_ready  = bus_ready;
          mem_w_last_i = bus_last;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_axi_sched.sv
// Bench for ysyx_22041412_axi_sched: bridge model, txn/beat
// scoreboards, starvation, cancel, length-error and reset cases.
module tb_ysyx_22041412_axi_sched;
  import ysyx_22041412_axi_pkg::*;

  localparam logic [31:0] A_IF = 32'h8000_0000;
  localparam logic [31:0] A_MR = 32'h8000_1000;
  localparam logic [31:0] A_MW = 32'h8000_2000;
  localparam int OW_IF = 0;
  localparam int OW_MR = 1;
  localparam int OW_MW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ar_valid;
  logic [31:0] if_ar_addr;
  logic [7:0]  if_ar_len;
  logic        if_ar_ready;
  logic [63:0] if_ar_data;
  logic        if_last_i;
  logic        mem_r_valid;
  logic [31:0] mem_r_addr;
  logic [7:0]  mem_r_len;
  logic        mem_r_ready;
  logic [63:0] mem_r_data;
  logic        mem_r_last_i;
  logic        mem_w_valid;
  logic [31:0] mem_w_addr;
  logic [7:0]  mem_w_len;
  logic [2:0]  mem_w_size;
  logic [63:0] mem_w_data;
  logic        mem_w_ready;
  logic        mem_w_last_i;
  logic        bus_valid;
  logic        bus_wen;
  logic [31:0] bus_addr;
  logic [7:0]  bus_len;
  logic [2:0]  bus_size;
  logic [63:0] bus_wdata;
  logic        bus_ready;
  logic [63:0] bus_rdata;
  logic        bus_last;

  int n_chk = 0;
  int n_err = 0;

  logic [32:0] q_txn[$];
  logic [64:0] q_if[$];
  logic [64:0] q_mr[$];
  logic [64:0] q_mw[$];
  logic        bv_prev = 1'b0;

  always #5 clk = ~clk;

  ysyx_22041412_axi_sched dut (
    .clk         (clk),
    .rst         (rst),
    .if_ar_valid (if_ar_valid),
    .if_ar_addr  (if_ar_addr),
    .if_ar_len   (if_ar_len),
    .if_ar_ready (if_ar_ready),
    .if_ar_data  (if_ar_data),
    .if_last_i   (if_last_i),
    .mem_r_valid (mem_r_valid),
    .mem_r_addr  (mem_r_addr),
    .mem_r_len   (mem_r_len),
    .mem_r_ready (mem_r_ready),
    .mem_r_data  (mem_r_data),
    .mem_r_last_i(mem_r_last_i),
    .mem_w_valid (mem_w_valid),
    .mem_w_addr  (mem_w_addr),
    .mem_w_len   (mem_w_len),
    .mem_w_size  (mem_w_size),
    .mem_w_data  (mem_w_data),
    .mem_w_ready (mem_w_ready),
    .mem_w_last_i(mem_w_last_i),
    .bus_valid   (bus_valid),
    .bus_wen     (bus_wen),
    .bus_addr    (bus_addr),
    .bus_len     (bus_len),
    .bus_size    (bus_size),
    .bus_wdata   (bus_wdata),
    .bus_ready   (bus_ready),
    .bus_rdata   (bus_rdata),
    .bus_last    (bus_last)
  );

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // bridge model: wait for the grant, then return nb beats
  task automatic serve(input int owner, input int nb,
                       input int last_at, input logic [63:0] base);
    int n;
    logic [63:0] d;
    n = 0;
    while (!bus_valid && n < 20) begin
      tick();
      n++;
    end
    check("grant_timeout", 128'(n < 20), 128'(1));
    for (int i = 0; i < nb; i++) begin
      d = base * 64'(i + 1);
      bus_ready = 1'b1;
      bus_rdata = d;
      bus_last  = (i == last_at);
      case (owner)
        OW_IF:   q_if.push_back({bus_last, d});
        OW_MR:   q_mr.push_back({bus_last, d});
        default: q_mw.push_back({bus_last, 64'h0});
      endcase
      tick();
    end
    bus_ready = 1'b0;
    bus_rdata = '0;
    bus_last  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_valid && !bv_prev) begin
        if (q_txn.size() == 0) check("txn_extra", 128'(1), 128'(0));
        else check("txn_owner", 128'({bus_wen, bus_addr}), 128'(q_txn.pop_front()));
      end
      if (bus_valid) begin
        check("bus_wen", 128'(bus_wen), 128'(bus_addr == A_MW));
        check("bus_size", 128'(bus_size),
              128'((bus_addr == A_MW) ? mem_w_size : 3'b011));
        if (bus_wen) check("bus_wdata", 128'(bus_wdata), 128'(mem_w_data));
      end
      if (if_ar_ready) begin
        if (q_if.size() == 0) check("if_spurious", 128'(1), 128'(0));
        else check("if_beat", 128'({if_last_i, if_ar_data}), 128'(q_if.pop_front()));
        check("if_excl", 128'({mem_r_ready, mem_r_data, mem_r_last_i,
                               mem_w_ready, mem_w_last_i}), 128'(0));
      end
      if (mem_r_ready) begin
        if (q_mr.size() == 0) check("mr_spurious", 128'(1), 128'(0));
        else check("mr_beat", 128'({mem_r_last_i, mem_r_data}), 128'(q_mr.pop_front()));
        check("mr_excl", 128'({if_ar_ready, if_ar_data, if_last_i, mem_w_ready}), 128'(0));
      end
      if (mem_w_ready) begin
        if (q_mw.size() == 0) check("mw_spurious", 128'(1), 128'(0));
        else check("mw_beat", 128'({mem_w_last_i, 64'h0}), 128'(q_mw.pop_front()));
        check("mw_excl", 128'({if_ar_ready, mem_r_ready, mem_r_data}), 128'(0));
      end
    end
    bv_prev = bus_valid;
  end

  initial begin
    int n;
    rst = 1'b1;
    if_ar_valid = 0; if_ar_addr = A_IF; if_ar_len = 0;
    mem_r_valid = 0; mem_r_addr = A_MR; mem_r_len = 0;
    mem_w_valid = 0; mem_w_addr = A_MW; mem_w_len = 0;
    mem_w_size = 3'b010; mem_w_data = 64'hDEAD_BEEF_0000_0001;
    bus_ready = 0; bus_rdata = 0; bus_last = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_bus_valid", 128'(bus_valid), 128'(0));
    check("rst_readies", 128'({if_ar_ready, mem_r_ready, mem_w_ready}), 128'(0));
    check("rst_state", 128'(dut.state_q), 128'(SCHED_IDLE));
    check("rst_starve", 128'(dut.starve_q), 128'(0));
    check("rst_beat", 128'(dut.beat_q), 128'(0));
    check("rst_err", 128'(dut.err_q), 128'(0));
    tick();

    // IF only, 4 beats 0x11..0x44
    if_ar_valid = 1; if_ar_len = 8'd3;
    q_txn.push_back({1'b0, A_IF});
    serve(OW_IF, 4, 3, 64'h11);
    if_ar_valid = 0;
    check("if_done_idle", 128'(dut.state_q), 128'(SCHED_IDLE));
    check("if_done_len_ok", 128'(dut.err_q), 128'(0));
    tick();

    // all three at once: MW, MR, IF
    mem_w_valid = 1; mem_w_len = 8'd1;
    mem_r_valid = 1; mem_r_len = 8'd0;
    if_ar_valid = 1; if_ar_len = 8'd0;
    q_txn.push_back({1'b1, A_MW});
    q_txn.push_back({1'b0, A_MR});
    q_txn.push_back({1'b0, A_IF});
    serve(OW_MW, 2, 1, 64'h0);
    mem_w_valid = 0;
    serve(OW_MR, 1, 0, 64'h0A0A);
    mem_r_valid = 0;
    serve(OW_IF, 1, 0, 64'h0B0B);
    if_ar_valid = 0;
    check("sim_starve_clr", 128'(dut.starve_q), 128'(0));
    tick();

    // starvation: 4 MEM reads, then IF, then MEM read again
    if_ar_valid = 1; if_ar_len = 8'd0;
    mem_r_valid = 1; mem_r_len = 8'd0;
    for (int k = 0; k < 4; k++) q_txn.push_back({1'b0, A_MR});
    q_txn.push_back({1'b0, A_IF});
    q_txn.push_back({1'b0, A_MR});
    for (int k = 0; k < 4; k++) serve(OW_MR, 1, 0, 64'h100 + 64'(k));
    check("starve_full", 128'(dut.starve_q), 128'(4));
    serve(OW_IF, 1, 0, 64'h777);
    check("starve_after_if", 128'(dut.starve_q), 128'(0));
    if_ar_valid = 0;
    serve(OW_MR, 1, 0, 64'h200);
    mem_r_valid = 0;
    tick();

    // cancel: MEM read granted then withdrawn, pending IF follows
    if_ar_valid = 1; if_ar_len = 8'd0;
    mem_r_valid = 1; mem_r_len = 8'd0;
    q_txn.push_back({1'b0, A_MR});
    q_txn.push_back({1'b0, A_IF});
    n = 0;
    while (!bus_valid && n < 20) begin
      tick();
      n++;
    end
    check("cancel_grant_timeout", 128'(n < 20), 128'(1));
    tick();
    mem_r_valid = 0;
    tick();
    check("cancel_idle", 128'(dut.state_q), 128'(SCHED_IDLE));
    check("cancel_starve_kept", 128'(dut.starve_q), 128'(1));
    serve(OW_IF, 1, 0, 64'h3C3C);
    if_ar_valid = 0;
    tick();

    // length mismatch: len 3, last on beat 2
    check("err_before", 128'(dut.err_q), 128'(0));
    mem_r_valid = 1; mem_r_len = 8'd3;
    q_txn.push_back({1'b0, A_MR});
    serve(OW_MR, 2, 1, 64'h5A);
    mem_r_valid = 0;
    check("len_err_idle", 128'(dut.state_q), 128'(SCHED_IDLE));
    check("len_err_set", 128'(dut.err_q), 128'(1));
    tick(); tick(); tick();
    check("len_err_hold", 128'(dut.err_q), 128'(1));

    // reset during beat 2 of an IF burst
    if_ar_valid = 1; if_ar_len = 8'd3;
    q_txn.push_back({1'b0, A_IF});
    n = 0;
    while (!bus_valid && n < 20) begin
      tick();
      n++;
    end
    check("rstb_grant_timeout", 128'(n < 20), 128'(1));
    bus_ready = 1; bus_rdata = 64'h55; bus_last = 0;
    q_if.push_back({1'b0, 64'h55});
    tick();
    rst = 1'b1;
    bus_rdata = 64'h66;
    #1;
    check("rstb_ready_zero", 128'(if_ar_ready), 128'(0));
    check("rstb_bus_zero", 128'({bus_valid, bus_addr, bus_len}), 128'(0));
    tick();
    bus_ready = 0; bus_rdata = 0;
    check("rstb_out_zero", 128'({bus_valid, if_ar_ready, if_ar_data}), 128'(0));
    rst = 1'b0;
    #1;
    check("rstb_state", 128'(dut.state_q), 128'(SCHED_IDLE));
    check("rstb_err_clr", 128'(dut.err_q), 128'(0));
    check("rstb_idle_bus", 128'(bus_valid), 128'(0));
    q_txn.push_back({1'b0, A_IF});
    serve(OW_IF, 4, 3, 64'h10);
    if_ar_valid = 0;
    check("rstb_after_ok", 128'(dut.err_q), 128'(0));
    tick(); tick();

    check("q_txn_left", 128'(q_txn.size()), 128'(0));
    check("q_beat_left", 128'(q_if.size() + q_mr.size() + q_mw.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
